// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side pointer/empty/fill control; define FIFO_RD_ALMOST_EMPTY_EN to add ralmost_empty
module fifo_rd_ctrl #(
  parameter int ADDR = 3,
  parameter int AE_LEVEL = 2
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rinc,
  input  logic [ADDR:0]   wptr_gray,
  output logic [ADDR-1:0] raddr,
  output logic [ADDR:0]   rptr_gray,
  output logic            rempty,
  output logic [ADDR:0]   rfill,
  output logic            rd_underflow
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic            ralmost_empty
`endif
);
  logic [ADDR:0] rq1, rq2, rbin, rbin_next, rgray_next, wbin_s, rlevel;
  logic acc;
  always_comb begin
    acc = rinc & ~rempty;
    rbin_next = rbin + (ADDR+1)'(acc);
    rgray_next = rbin_next ^ (rbin_next >> 1);
    wbin_s = '0;
    for (int i = 0; i <= ADDR; i++) wbin_s[i] = ^(rq2 >> i);
    rlevel = wbin_s - rbin_next;
  end
  assign raddr = rbin[ADDR-1:0];
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rq1 <= '0;
      rq2 <= '0;
      rbin <= '0;
      rptr_gray <= '0;
      rempty <= 1'b1;
      rfill <= '0;
      rd_underflow <= 1'b0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      ralmost_empty <= 1'b1;
`endif
    end else begin
      rq1 <= wptr_gray;
      rq2 <= rq1;
      rbin <= rbin_next;
      rptr_gray <= rgray_next;
      rempty <= rgray_next == rq2;
      rfill <= rlevel;
      rd_underflow <= rinc & rempty;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      ralmost_empty <= rlevel <= (ADDR+1)'(AE_LEVEL);
`endif
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench with a pointer-count model checked every cycle
module tb_fifo_rd_ctrl;
  logic rclk = 0, rrst_n = 0, rinc = 0;
  logic [3:0] wcnt = 0;
  logic [3:0] wptr_gray, rptr_gray, rfill;
  logic [2:0] raddr;
  logic rempty, rd_underflow;
  int checks = 0, failures = 0;
  bit seen15, seen0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic ralmost_empty;
`endif
  assign wptr_gray = wcnt ^ (wcnt >> 1);
  fifo_rd_ctrl #(.ADDR(3), .AE_LEVEL(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr_gray(wptr_gray),
    .raddr(raddr), .rptr_gray(rptr_gray), .rempty(rempty), .rfill(rfill),
    .rd_underflow(rd_underflow)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , .ralmost_empty(ralmost_empty)
`endif
  );
  always #5 rclk = ~rclk;
  int m_s1, m_s2, m_rd, m_fill;
  bit m_empty, m_uf;
  always @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      m_s1 = 0; m_s2 = 0; m_rd = 0; m_fill = 0; m_empty = 1; m_uf = 0;
    end else begin
      m_uf = rinc && m_empty;
      m_rd = (m_rd + int'(rinc && !m_empty)) % 16;
      m_fill = (m_s2 - m_rd + 16) % 16;
      m_empty = m_fill == 0;
      m_s2 = m_s1;
      m_s1 = int'(wcnt);
    end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge rclk)
    if (rrst_n) begin
      chk("m_raddr", int'(raddr), m_rd % 8);
      chk("m_rptr_gray", int'(rptr_gray), m_rd ^ (m_rd >> 1));
      chk("m_rempty", int'(rempty), int'(m_empty));
      chk("m_rfill", int'(rfill), m_fill);
      chk("m_underflow", int'(rd_underflow), int'(m_uf));
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      chk("m_almost_empty", int'(ralmost_empty), int'(m_fill <= 2));
`endif
    end
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask
  task automatic drain(input int n);
    rinc = 1;
    repeat (n) begin
      tick();
      if (rptr_gray == 4'b1000) seen15 = 1;
      if (seen15 && rptr_gray == 4'b0000) seen0 = 1;
    end
    rinc = 0;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_rfill", int'(rfill), 0);
    rrst_n = 1;
    tick();
    wcnt = 3;
    tick(); chk("vis_e1", int'(rempty), 1);
    tick(); chk("vis_e2", int'(rempty), 1);
    tick(); chk("vis_e3", int'(rempty), 0); chk("vis_fill", int'(rfill), 3);
    drain(3);
    chk("drain_raddr", int'(raddr), 3);
    chk("drain_empty", int'(rempty), 1);
    chk("drain_fill", int'(rfill), 0);
    chk("drain_gray", int'(rptr_gray), 4'b0010);
    rinc = 1; tick();
    chk("uf_pulse", int'(rd_underflow), 1);
    chk("uf_raddr", int'(raddr), 3);
    rinc = 0; tick();
    chk("uf_clear", int'(rd_underflow), 0);
    wcnt = wcnt + 8; repeat (3) tick();
    chk("wrap1_fill", int'(rfill), 8);
    drain(8);
    chk("wrap1_raddr", int'(raddr), 3);
    chk("wrap1_gray", int'(rptr_gray), 4'b1110);
    chk("wrap1_empty", int'(rempty), 1);
    wcnt = wcnt + 8; repeat (3) tick();
    drain(8);
    chk("wrap2_gray", int'(rptr_gray), 4'b0010);
    chk("wrap2_empty", int'(rempty), 1);
    chk("wrap_seen15", int'(seen15), 1);
    chk("wrap_seen0", int'(seen0), 1);
    wcnt = wcnt + 4; repeat (3) tick();
    chk("ae_fill4", int'(rfill), 4);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("ae_at4", int'(ralmost_empty), 0);
`endif
    rinc = 1;
    for (int f = 3; f >= 0; f--) begin
      tick();
      chk("ae_fill", int'(rfill), f);
      chk("ae_empty", int'(rempty), int'(f == 0));
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      chk("ae_flag", int'(ralmost_empty), int'(f <= 2));
`endif
    end
    rinc = 0;
    wcnt = wcnt + 8; repeat (3) tick(); drain(8);
    wcnt = wcnt + 6; repeat (3) tick(); drain(6);
    wcnt = wcnt + 2; repeat (3) tick();
    chk("pre_rst_raddr", int'(raddr), 5);
    chk("pre_rst_empty", int'(rempty), 0);
    rinc = 1;
    #2 rrst_n = 0;
    #1;
    chk("arst_raddr", int'(raddr), 0);
    chk("arst_gray", int'(rptr_gray), 0);
    chk("arst_empty", int'(rempty), 1);
    chk("arst_fill", int'(rfill), 0);
    chk("arst_uf", int'(rd_underflow), 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("arst_ae", int'(ralmost_empty), 1);
`endif
    rinc = 0;
    tick(); rrst_n = 1;
    repeat (3) tick();
    chk("post_rst_fill", int'(rfill), 7);
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
